l3_mshr_ctrl: RTL
=================

# l3_mshr_ctrl

Parametrised L3 miss-status-handling controller: tracks outstanding line misses, merges secondary misses to the same line into a per-entry target list, issues one downstream refill request per line, and replays all merged targets in order once the fill returns. It sits between the L3 tag-lookup pipeline (request side) and the memory-side refill path (miss/fill side), replacing the single-target MSHR table.

## Interface
- NUM_MSHR, 16, number of entries (power of two, 2..64)
- NUM_TGT, 4, targets per entry (1..8)
- ADDR_WIDTH, 32, byte address width
- LINE_BYTES, 64, line size; OFF_W = $clog2(LINE_BYTES)
- ID_WIDTH, 8, requester id width
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1  lookup-miss request handshake
- req_addr  in  ADDR_WIDTH  byte address
- req_id  in  ID_WIDTH  requester id
- req_write  in  1  1 = write miss
- miss_valid / miss_ready  out / in  1  refill request handshake
- miss_addr  out  ADDR_WIDTH-OFF_W  line address
- miss_tag  out  $clog2(NUM_MSHR)  entry index
- fill_valid / fill_ready  in / out  1  fill-complete handshake
- fill_tag  in  $clog2(NUM_MSHR)  entry being filled
- rsp_valid / rsp_ready  out / in  1  replay handshake
- rsp_id, rsp_write, rsp_offset  out  ID_WIDTH, 1, OFF_W  replayed target
- full  out  1  no IDLE entry
- busy_cnt  out  $clog2(NUM_MSHR)+1  non-IDLE entries
- err  out  1  sticky: fill to entry not in WAIT

## Operation
- Entry states: IDLE, ISSUE, WAIT, REPLAY. Entry holds line address, target count, target array {id, write, offset}.
- Match: valid (non-IDLE) entry with equal line address (req_addr[ADDR_WIDTH-1:OFF_W]); at most one.
- Primary miss (no match, free entry): allocate lowest-index IDLE entry -> ISSUE, target 0 stored, count=1.
- Secondary miss (match, entry ISSUE/WAIT, count<NUM_TGT): append at index count.
- req_ready=0 when: no match and full; match and count==NUM_TGT; match and entry REPLAY; match and fill_valid&&fill_ready&&fill_tag==match index.
- Miss issue: lowest-index ISSUE entry drives miss_*; ISSUE->WAIT on handshake. miss_* stable while miss_valid && !miss_ready.
- Fill: fill_ready=1 iff replay engine idle. Accepted fill to WAIT entry -> REPLAY; to any other state: no state change, err set.
- Replay engine: drains targets 0..count-1 of one REPLAY entry, one per rsp handshake; after last handshake entry -> IDLE, count cleared.
- Entry freed and new primary in same cycle: freed slot not allocatable until next cycle.
- busy_cnt: +1 on alloc, -1 on free, both in one cycle = unchanged.
- Reset mid-operation: all entries IDLE immediately, in-flight targets discarded, err cleared.

## Timing
- Reset values: req_ready=1, fill_ready=1, miss_valid=0, rsp_valid=0, full=0, busy_cnt=0, err=0, data outputs 0.
- req_ready, fill_ready: combinational from current state and inputs; no req_valid->req_ready dependency.
- Allocation on cycle N -> miss_valid earliest N+1; full/busy_cnt update N+1.
- Fill accepted cycle N -> rsp_valid first target N+1; back-to-back targets at one per cycle with rsp_ready=1.
- Last rsp handshake cycle N -> entry IDLE and reallocatable N+1; fill_ready=1 in N+1.
- Secondary appended cycle N on a WAIT entry is included in replay if fill accepted >= N+1.

## Structure
- Package l3_mshr_pkg: entry-state enum, target struct, entry struct, OFF_W/index-width helper functions.
- Sub-module l3_mshr_prio_enc: parametrised lowest-index first-set encoder with any-bit; instantiated for free-entry select and ISSUE select.

## Test plan
- Reset, then 16 primary misses to distinct lines, miss_ready=1 -> miss_tag 0..15 in order, full=1, 17th req_ready=0.
- Four requests to line 0x1000 (ids 1..4), fifth -> fifth stalled; fill tag 0 -> rsp_id 1,2,3,4 on consecutive cycles, fifth accepted after entry IDLE.
- Fill tag 0 and req to same line in same cycle -> req_ready=0, replay contains only prior targets.
- rsp_ready toggling 1/0 -> rsp_* held stable while stalled, no target lost or duplicated, fill_ready=0 throughout replay.
- Fill to IDLE entry 5 -> err=1 sticky, no rsp_valid, busy_cnt unchanged.
- rst_n asserted mid-replay -> all outputs at reset values asynchronously; next request allocates entry 0.

Source files
------------

// File: rtl/l3_mshr_pkg.sv
// rtl/l3_mshr_pkg.sv - shared types and width helpers for the L3 MSHR controller
package l3_mshr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPLAY = 2'd3
    } ent_state_e;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // Index width that never collapses to zero for single-element arrays
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l3_mshr_if.sv
// rtl/l3_mshr_if.sv - request, refill, fill and replay handshakes plus status of the MSHR controller
interface l3_mshr_if
    import l3_mshr_pkg::*;
#(
    parameter int NUM_MSHR   = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 64,
    parameter int ID_WIDTH   = 8
) ();
    localparam int OFF_W = off_w(LINE_BYTES);
    localparam int IDX_W = idx_w(NUM_MSHR);

    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [ID_WIDTH-1:0]     req_id;
    logic                    req_write;
    logic                    miss_valid;
    logic                    miss_ready;
    logic [ADDR_WIDTH-OFF_W-1:0] miss_addr;
    logic [IDX_W-1:0]        miss_tag;
    logic                    fill_valid;
    logic                    fill_ready;
    logic [IDX_W-1:0]        fill_tag;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_WIDTH-1:0]     rsp_id;
    logic                    rsp_write;
    logic [OFF_W-1:0]        rsp_offset;
    logic                    full;
    logic [IDX_W:0]          busy_cnt;
    logic                    err;

    modport slave (
        input  req_valid, req_addr, req_id, req_write, miss_ready, fill_valid, fill_tag, rsp_ready,
        output req_ready, miss_valid, miss_addr, miss_tag, fill_ready,
               rsp_valid, rsp_id, rsp_write, rsp_offset, full, busy_cnt, err
    );

    modport master (
        output req_valid, req_addr, req_id, req_write, miss_ready, fill_valid, fill_tag, rsp_ready,
        input  req_ready, miss_valid, miss_addr, miss_tag, fill_ready,
               rsp_valid, rsp_id, rsp_write, rsp_offset, full, busy_cnt, err
    );

endinterface

// File: rtl/l3_mshr_prio_enc.sv
// rtl/l3_mshr_prio_enc.sv - lowest-index first-set encoder with any-bit
module l3_mshr_prio_enc
    import l3_mshr_pkg::*;
#(
    parameter int  N = 16,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/l3_mshr_ctrl.sv
// rtl/l3_mshr_ctrl.sv - multi-target L3 MSHR: merge misses per line, issue one refill, replay targets in order
module l3_mshr_ctrl
    import l3_mshr_pkg::*;
#(
    parameter int NUM_MSHR   = 16,
    parameter int NUM_TGT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 64,
    parameter int ID_WIDTH   = 8
) (
    input logic      clk,
    input logic      rst_n,
    l3_mshr_if.slave bus
);
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(NUM_MSHR);
    localparam int TGT_W  = idx_w(NUM_TGT);
    localparam int CNT_W  = $clog2(NUM_TGT + 1);
    localparam int LINE_W = ADDR_WIDTH - OFF_W;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic                write;
        logic [OFF_W-1:0]    offset;
    } tgt_t;

    ent_state_e        state_q [NUM_MSHR];
    ent_state_e        state_d [NUM_MSHR];
    logic [LINE_W-1:0] line_q  [NUM_MSHR];
    logic [CNT_W-1:0]  cnt_q   [NUM_MSHR];
    tgt_t              tgt_q   [NUM_MSHR][NUM_TGT];

    logic [LINE_W-1:0]   req_line;
    tgt_t                req_tgt;
    logic [NUM_MSHR-1:0] hit_vec, free_vec, issue_vec;
    logic [IDX_W-1:0]    match_idx, free_idx, issue_sel, miss_idx;
    logic                match_any, free_any, issue_any;
    logic                req_ready, req_fire, alloc, append;
    logic                miss_fire, fill_fire, fill_ok, rsp_fire, rsp_last, free_fire;
    logic                hold_q;
    logic [IDX_W-1:0]    hold_idx_q;
    logic                rp_active_q;
    logic [IDX_W-1:0]    rp_idx_q;
    logic [TGT_W-1:0]    rp_ptr_q;
    logic [IDX_W:0]      busy_q;
    logic                err_q;
    tgt_t                rsp_tgt;

    assign req_line = bus.req_addr[ADDR_WIDTH-1:OFF_W];
    assign req_tgt  = '{id: bus.req_id, write: bus.req_write, offset: bus.req_addr[OFF_W-1:0]};

    always_comb begin
        match_idx = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            hit_vec[i]   = (state_q[i] != ST_IDLE) && (line_q[i] == req_line);
            free_vec[i]  = (state_q[i] == ST_IDLE);
            issue_vec[i] = (state_q[i] == ST_ISSUE);
            if (hit_vec[i]) match_idx = match_idx | IDX_W'(i);
        end
    end
    assign match_any = |hit_vec;

    l3_mshr_prio_enc #(.N(NUM_MSHR)) u_free_enc  (.vec(free_vec),  .idx(free_idx),  .any(free_any));
    l3_mshr_prio_enc #(.N(NUM_MSHR)) u_issue_enc (.vec(issue_vec), .idx(issue_sel), .any(issue_any));

    // A stalled refill keeps its entry even if a lower-index entry enters ISSUE meanwhile
    assign miss_idx       = hold_q ? hold_idx_q : issue_sel;
    assign bus.miss_valid = issue_any;
    assign bus.miss_tag   = issue_any ? miss_idx : '0;
    assign bus.miss_addr  = issue_any ? line_q[miss_idx] : '0;
    assign miss_fire      = issue_any && bus.miss_ready;

    assign bus.fill_ready = !rp_active_q;
    assign fill_fire      = bus.fill_valid && !rp_active_q;
    assign fill_ok        = fill_fire && (state_q[bus.fill_tag] == ST_WAIT);

    assign rsp_tgt        = tgt_q[rp_idx_q][rp_ptr_q];
    assign rsp_fire       = rp_active_q && bus.rsp_ready;
    assign rsp_last       = (CNT_W'(rp_ptr_q) + CNT_W'(1)) == cnt_q[rp_idx_q];
    assign free_fire      = rsp_fire && rsp_last;
    assign bus.rsp_valid  = rp_active_q;
    assign bus.rsp_id     = rp_active_q ? rsp_tgt.id     : '0;
    assign bus.rsp_write  = rp_active_q ? rsp_tgt.write  : 1'b0;
    assign bus.rsp_offset = rp_active_q ? rsp_tgt.offset : '0;

    // Merging into an entry whose fill lands this cycle would miss the replay snapshot
    always_comb begin
        if (match_any)
            req_ready = (state_q[match_idx] != ST_REPLAY) &&
                        (cnt_q[match_idx] != CNT_W'(NUM_TGT)) &&
                        !(fill_fire && (bus.fill_tag == match_idx));
        else
            req_ready = free_any;
    end
    assign bus.req_ready = req_ready;
    assign req_fire      = bus.req_valid && req_ready;
    assign alloc         = req_fire && !match_any;
    assign append        = req_fire && match_any;

    assign bus.full     = !free_any;
    assign bus.busy_cnt = busy_q;
    assign bus.err      = err_q;

    always_comb begin
        state_d = state_q;
        if (alloc)     state_d[free_idx]     = ST_ISSUE;
        if (miss_fire) state_d[miss_idx]     = ST_WAIT;
        if (fill_ok)   state_d[bus.fill_tag] = ST_REPLAY;
        if (free_fire) state_d[rp_idx_q]     = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            hold_q      <= 1'b0;
            hold_idx_q  <= '0;
            rp_active_q <= 1'b0;
            rp_idx_q    <= '0;
            rp_ptr_q    <= '0;
            busy_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= issue_any && !bus.miss_ready;
            hold_idx_q <= miss_idx;
            if (alloc)     cnt_q[free_idx]  <= CNT_W'(1);
            if (append)    cnt_q[match_idx] <= cnt_q[match_idx] + CNT_W'(1);
            if (free_fire) cnt_q[rp_idx_q]  <= '0;
            if (fill_fire && !fill_ok) err_q <= 1'b1;
            if (fill_ok) begin
                rp_active_q <= 1'b1;
                rp_idx_q    <= bus.fill_tag;
                rp_ptr_q    <= '0;
            end else if (rsp_fire) begin
                if (rsp_last) rp_active_q <= 1'b0;
                else          rp_ptr_q    <= rp_ptr_q + TGT_W'(1);
            end
            busy_q <= busy_q + (IDX_W + 1)'(alloc) - (IDX_W + 1)'(free_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            line_q[free_idx]   <= req_line;
            tgt_q[free_idx][0] <= req_tgt;
        end
        if (append) tgt_q[match_idx][cnt_q[match_idx][TGT_W-1:0]] <= req_tgt;
    end

endmodule
